cvita_ingress_buffer: RTL and testbench
=======================================

CVITA_INGRESS_BUFFER -- requirements
Module: cvita_ingress_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning CVITA tdata width in bits.
REQ-002 SHALL have parameter SIZE, default 5, meaning log2 of buffer depth in words (depth = 2^SIZE).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  meaning synchronous flush, active-high.
REQ-006 SHALL have ports i_tdata/i_tlast/i_tvalid  input  WIDTH/1/1  meaning the upstream CVITA stream.
REQ-007 SHALL have port i_tready  output  1  meaning upstream ready.
REQ-008 SHALL have ports o_tdata/o_tlast/o_tvalid  output  WIDTH/1/1  meaning the CVITA stream to one crossbar input.
REQ-009 SHALL have port o_tready  input  1  meaning crossbar ready.
REQ-010 SHALL have port pkt_present  output  1  meaning at least one complete packet is buffered; drives the crossbar pkt_present bit.
REQ-011 SHALL have port pkt_count  output  SIZE+1  meaning the number of complete buffered packets.
REQ-012 SHALL have port occupied  output  SIZE+1  meaning the number of words held, committed plus partial.
REQ-013 SHALL have port drop_count  output  16  meaning the number of oversize packets dropped; wraps.

Function
REQ-014 SHALL operate store-and-forward: no beat of a packet is presented on the o_* side until its tlast beat is written.
REQ-015 SHALL keep write pointer wr_ptr, committed pointer cm_ptr and read pointer rd_ptr, each SIZE+1 bits with a wrap bit; full = (wr_ptr - rd_ptr == 2^SIZE).
REQ-016 SHALL write a beat on i_tvalid && i_tready at mem[wr_ptr], storing {tlast, tdata}, then increment wr_ptr.
REQ-017 SHALL, on a written beat with i_tlast=1, set cm_ptr to wr_ptr+1 and increment pkt_count.
REQ-018 SHALL assert o_tvalid iff rd_ptr != cm_ptr; o_tdata/o_tlast are read combinationally from mem[rd_ptr]; a packet is visible on the output the cycle after its tlast write.
REQ-019 SHALL increment rd_ptr on o_tvalid && o_tready, and decrement pkt_count when that beat has o_tlast=1; a simultaneous increment and decrement leaves pkt_count unchanged.
REQ-020 SHALL assert pkt_present = (pkt_count != 0), registered, with no other delay.
REQ-021 SHALL implement an ingress FSM with states ACCEPT and DROP.
REQ-022 ACCEPT: i_tready = !full.
REQ-023 ACCEPT->DROP SHALL occur when full && pkt_count==0 && i_tvalid (partial packet fills the buffer); in the same cycle wr_ptr rewinds to cm_ptr and drop_count increments.
REQ-024 DROP: i_tready = 1, beats are discarded without being written, and the FSM returns to ACCEPT after the i_tlast beat is accepted.
REQ-025 SHALL, when full with pkt_count>0, only backpressure (no drop); draining frees space.
REQ-026 SHALL have occupied = wr_ptr - rd_ptr.
REQ-027 clear SHALL set all pointers, pkt_count and drop_count to 0 and the FSM to ACCEPT on the next edge; partial and committed data are discarded, and beats handshaked during clear are discarded.

Reset
REQ-028 On reset SHALL asynchronously set: pointers=0, pkt_count=0, drop_count=0, FSM=ACCEPT, pkt_present=0, o_tvalid=0, i_tready=1 (buffer empty).
REQ-029 Reset mid-packet SHALL discard all contents; the upstream remainder after deassertion is accepted as a new packet.
REQ-030 Memory contents SHALL NOT require reset.

Structure
REQ-031 The FSM state enum (ACCEPT, DROP) and the drop-counter width constant SHALL be in shared package cvita_ingress_pkg.
REQ-032 The storage SHALL be one sub-module, cvita_ingress_ram: a 2^SIZE x (WIDTH+1) memory with synchronous write and asynchronous read.

Verification (SIZE=4, depth 16)
REQ-033 Write a 3-beat packet with o_tready=1: o_tvalid=0 until the cycle after the tlast write; 3 beats are output in order, with o_tlast on beat 3; pkt_count goes 0->1->0.
REQ-034 Write four 4-beat packets with o_tready=0: pkt_count=4, occupied=16, i_tready=0; raise o_tready: all 16 beats drain intact, no drop.
REQ-035 Write a 20-beat packet with o_tready=0: DROP is entered on beat 17, drop_count=1, pkt_count=0, occupied=0, beats 17-20 are accepted; a following 2-beat packet is delivered correctly.
REQ-036 Write a tlast beat while the output consumes another packet's tlast in the same cycle: pkt_count is unchanged.
REQ-037 Pulse clear mid-packet with 2 complete packets buffered: the next cycle shows pkt_count=0, occupied=0, o_tvalid=0.
REQ-038 Assert reset asynchronously in DROP: outputs take their reset values immediately; a clean 1-beat packet passes after deassertion.

Source files
------------

// File: rtl/cvita_ingress_pkg.sv
// Shared types and constants for the CVITA ingress buffer.
package cvita_ingress_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } ingress_state_e;

endpackage

// File: rtl/cvita_ingress_ram.sv
// Packet storage: synchronous write, asynchronous read, no reset on contents.
module cvita_ingress_ram #(
  parameter int unsigned WORD_W = 65,
  parameter int unsigned SIZE   = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [SIZE-1:0]   waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [SIZE-1:0]   raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << SIZE;

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cvita_ingress_buffer.sv
// Store-and-forward CVITA packet buffer feeding one crossbar input; packets
// that cannot fit in the buffer are dropped whole and counted.
module cvita_ingress_buffer
  import cvita_ingress_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SIZE  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      i_tdata,
  input  logic                  i_tlast,
  input  logic                  i_tvalid,
  output logic                  i_tready,
  output logic [WIDTH-1:0]      o_tdata,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  output logic                  pkt_present,
  output logic [SIZE:0]         pkt_count,
  output logic [SIZE:0]         occupied,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int unsigned PTR_W  = SIZE + 1;
  localparam int unsigned WORD_W = WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(1 << SIZE);

  ingress_state_e        state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      cm_ptr_q, cm_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      pkt_count_q, pkt_count_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
  logic                  pkt_present_q;

  logic              full_c;
  logic              in_ready_c;
  logic              out_valid_c;
  logic              rd_fire_c;
  logic              wr_en_c;
  logic              commit_c;
  logic              release_c;
  logic [WORD_W-1:0] rd_word_c;

  assign full_c      = (wr_ptr_q - rd_ptr_q) == DEPTH;
  assign out_valid_c = rd_ptr_q != cm_ptr_q;
  assign rd_fire_c   = out_valid_c && o_tready;

  // Ingress FSM, pointer and counter next-state logic.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cm_ptr_d     = cm_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    in_ready_c   = 1'b1;
    wr_en_c      = 1'b0;
    commit_c     = 1'b0;
    release_c    = 1'b0;

    case (state_q)
      ACCEPT: begin
        in_ready_c = !full_c;
        if (i_tvalid && !full_c) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (i_tlast) begin
            cm_ptr_d = wr_ptr_q + PTR_W'(1);
            commit_c = 1'b1;
          end
        end else if (i_tvalid && pkt_count_q == '0) begin
          // A partial packet alone fills the buffer: it can never commit.
          state_d      = DROP;
          wr_ptr_d     = cm_ptr_q;
          drop_count_d = drop_count_q + DROP_CNT_W'(1);
        end
      end
      DROP: begin
        in_ready_c = 1'b1;
        if (i_tvalid && i_tlast) begin
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase

    if (rd_fire_c) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      release_c = rd_word_c[WIDTH];
    end

    case ({commit_c, release_c})
      2'b10:   pkt_count_d = pkt_count_q + PTR_W'(1);
      2'b01:   pkt_count_d = pkt_count_q - PTR_W'(1);
      default: pkt_count_d = pkt_count_q;
    endcase

    if (clear) begin
      state_d      = ACCEPT;
      wr_ptr_d     = '0;
      cm_ptr_d     = '0;
      rd_ptr_d     = '0;
      pkt_count_d  = '0;
      drop_count_d = '0;
      wr_en_c      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ACCEPT;
      wr_ptr_q      <= '0;
      cm_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pkt_count_q   <= '0;
      drop_count_q  <= '0;
      pkt_present_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cm_ptr_q      <= cm_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pkt_count_q   <= pkt_count_d;
      drop_count_q  <= drop_count_d;
      pkt_present_q <= pkt_count_d != '0;
    end
  end

  cvita_ingress_ram #(
    .WORD_W(WORD_W),
    .SIZE  (SIZE)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_en_c),
    .waddr_i(wr_ptr_q[SIZE-1:0]),
    .wdata_i({i_tlast, i_tdata}),
    .raddr_i(rd_ptr_q[SIZE-1:0]),
    .rdata_o(rd_word_c)
  );

  assign i_tready          = in_ready_c;
  assign o_tvalid          = out_valid_c;
  assign {o_tlast, o_tdata} = rd_word_c;
  assign pkt_present       = pkt_present_q;
  assign pkt_count         = pkt_count_q;
  assign occupied          = wr_ptr_q - rd_ptr_q;
  assign drop_count        = drop_count_q;

endmodule

// File: tb/tb_cvita_ingress_buffer.sv
// Bench for cvita_ingress_buffer (depth 16) against a queue-based packet model.
module tb_cvita_ingress_buffer;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        pkt_present;
  logic [4:0]  pkt_count;
  logic [4:0]  occupied;
  logic [15:0] drop_count;

  cvita_ingress_buffer #(.WIDTH(32), .SIZE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .i_tdata    (i_tdata),
    .i_tlast    (i_tlast),
    .i_tvalid   (i_tvalid),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .pkt_present(pkt_present),
    .pkt_count  (pkt_count),
    .occupied   (occupied),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: committed-unread beats, partial packet, and beats expected downstream.
  beat_t       m_cmt[$];
  beat_t       m_part[$];
  beat_t       m_out[$];
  beat_t       got_q[$];
  beat_t       src_q[$];
  int unsigned m_drops;
  bit          m_dropping;
  bit          hold;
  int          flow_err;
  string       flow_msg;

  function automatic int m_pkts();
    int n = 0;
    foreach (m_cmt[i]) if (m_cmt[i].last) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    return m_dropping || ((m_cmt.size() + m_part.size()) < 16);
  endfunction

  function automatic void model_reset();
    m_cmt.delete(); m_part.delete(); m_out.delete(); got_q.delete();
    m_drops = 0; m_dropping = 0;
  endfunction

  function automatic bit model_step(input bit v, input beat_t b, input bit r, input bit clr);
    bit rdy  = m_ready();
    bit full = (m_cmt.size() + m_part.size()) == 16;
    int pk   = m_pkts();
    bit acc  = v && rdy;
    if (r && m_cmt.size() != 0) m_out.push_back(m_cmt.pop_front());
    if (clr) begin
      m_cmt.delete(); m_part.delete(); m_drops = 0; m_dropping = 0;
    end else if (m_dropping) begin
      if (v && b.last) m_dropping = 0;
    end else if (acc) begin
      m_part.push_back(b);
      if (b.last) begin
        foreach (m_part[i]) m_cmt.push_back(m_part[i]);
        m_part.delete();
      end
    end else if (v && full && pk == 0) begin
      m_dropping = 1;
      m_part.delete();
      m_drops = (m_drops + 1) & 32'hFFFF;
    end
    return acc;
  endfunction

  function automatic int sb_diff();
    int d = 0;
    if (got_q.size() != m_out.size()) d++;
    for (int i = 0; i < got_q.size() && i < m_out.size(); i++)
      if (got_q[i] !== m_out[i]) d++;
    return d;
  endfunction

  function automatic void add_pkt(input int len);
    for (int i = 0; i < len; i++) src_q.push_back(beat_t'({(i == len - 1), $urandom()}));
  endfunction

  // One clock: drive, sample at negedge, advance model, return at posedge+1.
  task automatic step(input bit v, input beat_t b, input bit r, input bit clr, output bit acc);
    int occ;
    i_tvalid = v; i_tlast = b.last; i_tdata = b.data; o_tready = r; clear = clr;
    @(negedge clk);
    occ = m_cmt.size() + m_part.size();
    if (i_tready !== m_ready() || o_tvalid !== (m_cmt.size() != 0) ||
        pkt_count !== 5'(m_pkts()) || pkt_present !== (m_pkts() != 0) ||
        occupied !== 5'(occ) || drop_count !== 16'(m_drops) ||
        (o_tvalid === 1'b1 && m_cmt.size() != 0 && beat_t'({o_tlast, o_tdata}) !== m_cmt[0])) begin
      if (flow_err == 0)
        flow_msg = $sformatf("t=%0t rdy=%b/%b vld=%b/%b cnt=%0d/%0d occ=%0d/%0d drop=%0d/%0d",
                             $time, i_tready, m_ready(), o_tvalid, (m_cmt.size() != 0),
                             pkt_count, m_pkts(), occupied, occ, drop_count, m_drops);
      flow_err++;
    end
    if (o_tvalid === 1'b1 && o_tready) got_q.push_back(beat_t'({o_tlast, o_tdata}));
    acc = model_step(v, b, r, clr);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0; clear = 1'b0;
  endtask

  task automatic run(input int n, input int vpct, input int rpct);
    bit v, r, acc;
    beat_t b;
    for (int c = 0; c < n; c++) begin
      v = (src_q.size() != 0) && (hold || (int'($urandom_range(99)) < vpct));
      b = (src_q.size() != 0) ? src_q[0] : '0;
      r = int'($urandom_range(99)) < rpct;
      step(v, b, r, 1'b0, acc);
      hold = v && !acc;
      if (acc) void'(src_q.pop_front());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0; o_tready = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (i_tready !== 1'b1) begin n_bad++; $display("FAIL reset_i_tready got %b want 1", i_tready); end
    n_cmp++; if (o_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_o_tvalid got %b want 0", o_tvalid); end
    n_cmp++; if (pkt_present !== 1'b0) begin n_bad++; $display("FAIL reset_pkt_present got %b want 0", pkt_present); end
    n_cmp++; if (pkt_count !== 5'd0) begin n_bad++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
    n_cmp++; if (occupied !== 5'd0) begin n_bad++; $display("FAIL reset_occupied got %0d want 0", occupied); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset(); src_q.delete(); hold = 0; flow_err = 0;
  endtask

  task automatic test_single_packet();
    beat_t b[3];
    bit acc;
    int d;
    for (int i = 0; i < 3; i++) b[i] = beat_t'({(i == 2), $urandom()});
    for (int i = 0; i < 3; i++) begin
      step(1'b1, b[i], 1'b1, 1'b0, acc);
      n_cmp++;
      if (o_tvalid !== (i == 2)) begin n_bad++; $display("FAIL single_visibility_beat%0d got %b want %b", i + 1, o_tvalid, (i == 2)); end
    end
    n_cmp++; if (pkt_count !== 5'd1) begin n_bad++; $display("FAIL single_pkt_count_committed got %0d want 1", pkt_count); end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
    n_cmp++; if (pkt_count !== 5'd0) begin n_bad++; $display("FAIL single_pkt_count_drained got %0d want 0", pkt_count); end
    d = 1;
    if (got_q.size() == 3) begin
      d = 0;
      for (int i = 0; i < 3; i++) if (got_q[i] !== b[i]) d++;
    end
    n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL single_beats got %0d beats %0d wrong want 3 in order", got_q.size(), d); end
    n_cmp++; if (flow_err !== 0) begin n_bad++; $display("FAIL single_cycle_model got %0d divergent cycles (%s) want 0", flow_err, flow_msg); end
    flow_err = 0; got_q.delete(); m_out.delete();
  endtask

  task automatic test_fill_four();
    for (int p = 0; p < 5; p++) add_pkt(4);
    run(20, 100, 0);
    n_cmp++; if (pkt_count !== 5'd4) begin n_bad++; $display("FAIL fill_pkt_count got %0d want 4", pkt_count); end
    n_cmp++; if (occupied !== 5'd16) begin n_bad++; $display("FAIL fill_occupied got %0d want 16", occupied); end
    n_cmp++; if (i_tready !== 1'b0) begin n_bad++; $display("FAIL fill_i_tready got %b want 0", i_tready); end
    n_cmp++; if (src_q.size() !== 4) begin n_bad++; $display("FAIL fill_blocked_beats got %0d want 4", src_q.size()); end
    run(60, 100, 100);
    n_cmp++; if (src_q.size() !== 0) begin n_bad++; $display("FAIL fill_source_timeout got %0d pending want 0", src_q.size()); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL fill_drop_count got %0d want 0", drop_count); end
    n_cmp++; if (got_q.size() !== 20 || sb_diff() !== 0) begin n_bad++; $display("FAIL fill_drain got %0d beats %0d diffs want 20 beats 0 diffs", got_q.size(), sb_diff()); end
    n_cmp++; if (flow_err !== 0) begin n_bad++; $display("FAIL fill_cycle_model got %0d divergent cycles (%s) want 0", flow_err, flow_msg); end
    flow_err = 0; got_q.delete(); m_out.delete();
  endtask

  task automatic test_oversize_drop();
    add_pkt(20);
    add_pkt(2);
    run(16, 100, 0);
    n_cmp++; if (occupied !== 5'd16 || pkt_count !== 5'd0) begin n_bad++; $display("FAIL drop_prefill got occ %0d cnt %0d want 16 0", occupied, pkt_count); end
    run(1, 100, 0);
    n_cmp++; if (drop_count !== 16'd1) begin n_bad++; $display("FAIL drop_count got %0d want 1", drop_count); end
    n_cmp++; if (occupied !== 5'd0 || pkt_count !== 5'd0) begin n_bad++; $display("FAIL drop_rewind got occ %0d cnt %0d want 0 0", occupied, pkt_count); end
    n_cmp++; if (i_tready !== 1'b1) begin n_bad++; $display("FAIL drop_i_tready got %b want 1", i_tready); end
    n_cmp++; if (src_q.size() !== 6) begin n_bad++; $display("FAIL drop_beat17_pending got %0d want 6", src_q.size()); end
    run(60, 100, 100);
    n_cmp++; if (src_q.size() !== 0) begin n_bad++; $display("FAIL drop_source_timeout got %0d pending want 0", src_q.size()); end
    n_cmp++; if (got_q.size() !== 2 || sb_diff() !== 0) begin n_bad++; $display("FAIL drop_followup got %0d beats %0d diffs want 2 beats 0 diffs", got_q.size(), sb_diff()); end
    n_cmp++; if (flow_err !== 0) begin n_bad++; $display("FAIL drop_cycle_model got %0d divergent cycles (%s) want 0", flow_err, flow_msg); end
    flow_err = 0; got_q.delete(); m_out.delete();
  endtask

  task automatic test_simultaneous();
    beat_t a0, a1, b0, b1;
    bit acc;
    a0 = beat_t'({1'b0, $urandom()}); a1 = beat_t'({1'b1, $urandom()});
    b0 = beat_t'({1'b0, $urandom()}); b1 = beat_t'({1'b1, $urandom()});
    step(1'b1, a0, 1'b0, 1'b0, acc);
    step(1'b1, a1, 1'b0, 1'b0, acc);
    step(1'b1, b0, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    n_cmp++; if (pkt_count !== 5'd1) begin n_bad++; $display("FAIL simul_before got %0d want 1", pkt_count); end
    step(1'b1, b1, 1'b1, 1'b0, acc);
    n_cmp++; if (pkt_count !== 5'd1) begin n_bad++; $display("FAIL simul_pkt_count got %0d want 1", pkt_count); end
    n_cmp++; if (o_tvalid !== 1'b1 || o_tdata !== b0.data) begin n_bad++; $display("FAIL simul_next_head got vld %b data %h want 1 %h", o_tvalid, o_tdata, b0.data); end
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    n_cmp++; if (pkt_count !== 5'd0 || pkt_present !== 1'b0) begin n_bad++; $display("FAIL simul_drained got cnt %0d present %b want 0 0", pkt_count, pkt_present); end
    n_cmp++; if (got_q.size() !== 4 || sb_diff() !== 0) begin n_bad++; $display("FAIL simul_beats got %0d beats %0d diffs want 4 beats 0 diffs", got_q.size(), sb_diff()); end
    n_cmp++; if (flow_err !== 0) begin n_bad++; $display("FAIL simul_cycle_model got %0d divergent cycles (%s) want 0", flow_err, flow_msg); end
    flow_err = 0; got_q.delete(); m_out.delete();
  endtask

  task automatic test_clear();
    bit acc;
    add_pkt(3); add_pkt(3); add_pkt(4);
    run(8, 100, 0);
    n_cmp++; if (pkt_count !== 5'd2 || occupied !== 5'd8) begin n_bad++; $display("FAIL clear_setup got cnt %0d occ %0d want 2 8", pkt_count, occupied); end
    n_cmp++; if (drop_count !== 16'd1) begin n_bad++; $display("FAIL clear_drop_before got %0d want 1", drop_count); end
    step(1'b1, src_q[0], 1'b0, 1'b1, acc);
    if (acc) void'(src_q.pop_front());
    hold = !acc;
    n_cmp++; if (pkt_count !== 5'd0 || occupied !== 5'd0) begin n_bad++; $display("FAIL clear_counts got cnt %0d occ %0d want 0 0", pkt_count, occupied); end
    n_cmp++; if (o_tvalid !== 1'b0) begin n_bad++; $display("FAIL clear_o_tvalid got %b want 0", o_tvalid); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL clear_drop_count got %0d want 0", drop_count); end
    run(20, 100, 100);
    n_cmp++; if (got_q.size() !== 1 || sb_diff() !== 0) begin n_bad++; $display("FAIL clear_remainder got %0d beats %0d diffs want 1 beat 0 diffs", got_q.size(), sb_diff()); end
    n_cmp++; if (flow_err !== 0) begin n_bad++; $display("FAIL clear_cycle_model got %0d divergent cycles (%s) want 0", flow_err, flow_msg); end
    flow_err = 0; got_q.delete(); m_out.delete();
  endtask

  task automatic test_random();
    for (int p = 0; p < 40; p++) add_pkt((p % 9 == 8) ? int'($urandom_range(24, 17)) : int'($urandom_range(10, 1)));
    for (int c = 0; c < 4000 && src_q.size() != 0; c++) run(1, 70, 60);
    n_cmp++; if (src_q.size() !== 0) begin n_bad++; $display("FAIL random_source_timeout got %0d pending want 0", src_q.size()); end
    run(40, 0, 100);
    n_cmp++; if (occupied !== 5'd0) begin n_bad++; $display("FAIL random_drained got occ %0d want 0", occupied); end
    n_cmp++; if (drop_count !== 16'd4) begin n_bad++; $display("FAIL random_drop_count got %0d want 4", drop_count); end
    n_cmp++; if (got_q.size() == 0 || sb_diff() !== 0) begin n_bad++; $display("FAIL random_scoreboard got %0d beats %0d diffs want >0 beats 0 diffs", got_q.size(), sb_diff()); end
    n_cmp++; if (flow_err !== 0) begin n_bad++; $display("FAIL random_cycle_model got %0d divergent cycles (%s) want 0", flow_err, flow_msg); end
    flow_err = 0; got_q.delete(); m_out.delete();
  endtask

  task automatic test_reset_in_drop();
    add_pkt(18);
    run(17, 100, 0);
    run(1, 100, 0);
    n_cmp++; if (drop_count !== 16'd5 || i_tready !== 1'b1) begin n_bad++; $display("FAIL rdrop_setup got drop %0d rdy %b want 5 1", drop_count, i_tready); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL rdrop_drop_count got %0d want 0", drop_count); end
    n_cmp++; if (i_tready !== 1'b1 || o_tvalid !== 1'b0) begin n_bad++; $display("FAIL rdrop_handshake got rdy %b vld %b want 1 0", i_tready, o_tvalid); end
    n_cmp++; if (pkt_count !== 5'd0 || occupied !== 5'd0 || pkt_present !== 1'b0) begin n_bad++; $display("FAIL rdrop_counts got cnt %0d occ %0d present %b want 0 0 0", pkt_count, occupied, pkt_present); end
    model_reset(); src_q.delete(); hold = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    add_pkt(1);
    run(10, 100, 100);
    n_cmp++; if (got_q.size() !== 1 || sb_diff() !== 0) begin n_bad++; $display("FAIL rdrop_clean_packet got %0d beats %0d diffs want 1 beat 0 diffs", got_q.size(), sb_diff()); end
    n_cmp++; if (flow_err !== 0) begin n_bad++; $display("FAIL rdrop_cycle_model got %0d divergent cycles (%s) want 0", flow_err, flow_msg); end
    flow_err = 0; got_q.delete(); m_out.delete();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_fill_four();
    test_oversize_drop();
    test_simultaneous();
    test_clear();
    test_random();
    test_reset_in_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
